// File: rtl/smul_seq_ctrl.sv
// Job sequencer for one rotation-LFSR stochastic multiplier lane: accepts an
// operand/seed job, loads the multiplier, counts CYC product bits, returns the count.
module smul_seq_ctrl #(
  parameter int DATAWD = 8,
  parameter int CYC    = 65025,
  parameter int CNTWD  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATAWD-1:0] in_a,
  input  logic [DATAWD-1:0] in_b,
  input  logic [DATAWD-1:0] in_seed_a,
  input  logic [DATAWD-1:0] in_seed_b,
  input  logic [DATAWD-1:0] in_seed_u,
  output logic [DATAWD-1:0] mul_ia,
  output logic [DATAWD-1:0] mul_ib,
  output logic [DATAWD-1:0] mul_seed_a,
  output logic [DATAWD-1:0] mul_seed_b,
  output logic [DATAWD-1:0] mul_seed_u,
  output logic              mul_load_a,
  output logic              mul_load_b,
  input  logic              mul_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNTWD-1:0]  out_cnt,
  output logic              busy
);

  localparam int CYCWD = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [CYCWD-1:0] CYC_LAST = CYCWD'(CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_r;
  logic [CYCWD-1:0]  cyc_r;
  logic [CNTWD-1:0]  acc_r;
  logic [CNTWD-1:0]  out_cnt_r;
  logic              out_valid_r;
  logic              mul_load_r;
  logic [DATAWD-1:0] hold_a_r;
  logic [DATAWD-1:0] hold_b_r;
  logic [DATAWD-1:0] hold_seed_a_r;
  logic [DATAWD-1:0] hold_seed_b_r;
  logic [DATAWD-1:0] hold_seed_u_r;

  // Saturating add of one product bit; the count never wraps.
  function automatic logic [CNTWD-1:0] sat_inc(input logic [CNTWD-1:0] v, input logic b);
    if (b && (v != {CNTWD{1'b1}})) begin
      return v + {{(CNTWD-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Sequencer FSM with its counters, holding registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cyc_r         <= '0;
      acc_r         <= '0;
      out_cnt_r     <= '0;
      out_valid_r   <= 1'b0;
      mul_load_r    <= 1'b0;
      hold_a_r      <= '0;
      hold_b_r      <= '0;
      hold_seed_a_r <= '0;
      hold_seed_b_r <= '0;
      hold_seed_u_r <= '0;
    end else begin
      mul_load_r <= 1'b0;
      if (abort) begin
        state_r     <= ST_IDLE;
        out_valid_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (in_valid) begin
              hold_a_r      <= in_a;
              hold_b_r      <= in_b;
              hold_seed_a_r <= in_seed_a;
              hold_seed_b_r <= in_seed_b;
              hold_seed_u_r <= in_seed_u;
              mul_load_r    <= 1'b1;
              state_r       <= ST_LOAD;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_LOAD: begin
            cyc_r   <= '0;
            acc_r   <= '0;
            state_r <= ST_RUN;
          end
          ST_RUN: begin
            // The last sampled bit goes straight into the result register.
            if (cyc_r == CYC_LAST) begin
              out_cnt_r   <= sat_inc(acc_r, mul_bit);
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              acc_r <= sat_inc(acc_r, mul_bit);
              cyc_r <= cyc_r + CYCWD'(1);
            end
          end
          ST_DONE: begin
            if (out_ready) begin
              out_valid_r <= 1'b0;
              state_r     <= ST_IDLE;
            end else begin
              out_valid_r <= 1'b1;
            end
          end
          default: begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // abort must veto an accept in the same cycle, so it gates in_ready directly.
  assign in_ready   = (state_r == ST_IDLE) && !abort;
  assign busy       = (state_r != ST_IDLE);
  assign out_valid  = out_valid_r;
  assign out_cnt    = out_cnt_r;
  assign mul_load_a = mul_load_r;
  assign mul_load_b = mul_load_r;
  assign mul_ia     = hold_a_r;
  assign mul_ib     = hold_b_r;
  assign mul_seed_a = hold_seed_a_r;
  assign mul_seed_b = hold_seed_b_r;
  assign mul_seed_u = hold_seed_u_r;

endmodule

// File: tb/tb_smul_seq_ctrl.sv
// Directed self-checking bench for smul_seq_ctrl with a short stream (CYC=16);
// the bench drives mul_bit itself in place of the multiplier.
module tb_smul_seq_ctrl;

  localparam int DATAWD = 8;
  localparam int CYC    = 16;
  localparam int CNTWD  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              abort = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATAWD-1:0] in_a = '0, in_b = '0, in_seed_a = '0, in_seed_b = '0, in_seed_u = '0;
  logic [DATAWD-1:0] mul_ia, mul_ib, mul_seed_a, mul_seed_b, mul_seed_u;
  logic              mul_load_a, mul_load_b;
  logic              mul_bit = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CNTWD-1:0]  out_cnt;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  smul_seq_ctrl #(.DATAWD(DATAWD), .CYC(CYC), .CNTWD(CNTWD)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_seed_a(in_seed_a), .in_seed_b(in_seed_b), .in_seed_u(in_seed_u),
    .mul_ia(mul_ia), .mul_ib(mul_ib),
    .mul_seed_a(mul_seed_a), .mul_seed_b(mul_seed_b), .mul_seed_u(mul_seed_u),
    .mul_load_a(mul_load_a), .mul_load_b(mul_load_b),
    .mul_bit(mul_bit),
    .out_valid(out_valid), .out_ready(out_ready), .out_cnt(out_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Accept a job, drive pattern[i] as the i-th sampled bit, check the result,
  // hold out_ready low for nwait cycles, then complete the result handshake.
  task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] sd,
                         input logic [15:0] pattern, input int exp_cnt, input int nwait);
    in_valid = 1'b1; in_a = a; in_b = b;
    in_seed_a = sd; in_seed_b = sd + 8'd1; in_seed_u = sd + 8'd2;
    #1 check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_a = 8'hEE; in_b = 8'hDD; in_seed_a = 8'h11; in_seed_b = 8'h22; in_seed_u = 8'h33;
    #1;
    check("load_a_in_load", 32'(mul_load_a), 32'd1);
    check("load_b_in_load", 32'(mul_load_b), 32'd1);
    check("mul_ia", 32'(mul_ia), 32'(a));
    check("mul_ib", 32'(mul_ib), 32'(b));
    check("mul_seed_u", 32'(mul_seed_u), 32'(sd + 8'd2));
    check("busy_in_job", 32'(busy), 32'd1);
    for (int i = 0; i < CYC; i++) begin
      @(negedge clk);
      mul_bit = pattern[i];
      #1;
      if (i == 0) check("load_single_cycle", 32'(mul_load_a), 32'd0);
      if (i == CYC - 1) check("valid_not_early", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    mul_bit = 1'b1;
    #1;
    check("valid_at_T_plus_17", 32'(out_valid), 32'd1);
    check("out_cnt", 32'(out_cnt), 32'(exp_cnt));
    check("mul_ia_held_after_run", 32'(mul_ia), 32'(a));
    for (int k = 0; k < nwait; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      #1;
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_cnt_stable", 32'(out_cnt), 32'(exp_cnt));
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    mul_bit = 1'b0;
    #1;
    check("valid_dropped", 32'(out_valid), 32'd0);
    check("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int bad;
    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_cnt", 32'(out_cnt), 32'd0);
    check("rst_mul_load", 32'(mul_load_a | mul_load_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_job(8'd128, 8'd64, 8'h5A, 16'hFFFF, 16, 0);
    run_job(8'd3, 8'd200, 8'h01, 16'h5555, 8, 0);
    run_job(8'd0, 8'd9, 8'h77, 16'h0000, 0, 0);
    // Back-pressure, then a back-to-back job on the very next cycle
    run_job(8'd17, 8'd34, 8'h40, 16'h80F3, 7, 5);
    run_job(8'd99, 8'd1, 8'hC3, 16'hFFFE, 15, 0);

    // Abort in the 5th RUN cycle
    in_valid = 1'b1; in_a = 8'd44; in_b = 8'd55;
    @(negedge clk);
    in_valid = 1'b0;
    mul_bit = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < CYC + 4; i++) begin
      @(negedge clk);
      #1;
      if (out_valid || mul_load_a || mul_load_b || busy) bad++;
    end
    check("abort_no_result_no_load", 32'(bad), 32'd0);

    // abort together with in_valid in IDLE must not accept
    abort = 1'b1; in_valid = 1'b1;
    #1 check("abort_gates_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    #1;
    check("abort_no_accept", 32'(busy), 32'd0);
    check("abort_no_load", 32'(mul_load_a), 32'd0);

    // Asynchronous reset mid-RUN
    in_valid = 1'b1; in_a = 8'd77; in_b = 8'd88; in_seed_a = 8'd5;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_cnt", 32'(out_cnt), 32'd0);
    check("midrst_mul_load", 32'(mul_load_a | mul_load_b), 32'd0);
    check("midrst_mul_ia", 32'(mul_ia), 32'd0);
    check("midrst_seed_a", 32'(mul_seed_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(8'd250, 8'd250, 8'h99, 16'h0F0F, 8, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $finish;
  end

endmodule
